// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: byte FIFO between a UART receiver and sender.
// Bytes from the receiver are pushed into a circular buffer; a small drain
// FSM pops one byte at a time into out_data and strobes out_start, then
// follows the sender's tx_busy handshake before popping the next byte.
// Optional build macro UART_FIFO_OVF_STICKY_EN: when defined, overflow is
// sticky until reset; when undefined, overflow pulses for one cycle after
// each dropped byte.
module uart_byte_fifo #(
  parameter int AW        = 4,
  parameter int BUSY_WAIT = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          tx_busy,
  output logic [7:0]    out_data,
  output logic          out_start,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  localparam int DEPTH = 1 << AW;
  localparam int WW    = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  logic [7:0]    mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_start_q, out_start_d;
  logic [WW-1:0] wcnt_q, wcnt_d;

  logic          push, pop, drop;

  // Pop only from IDLE on registered flags, so a byte pushed into an empty
  // FIFO is never popped in the same cycle; a full FIFO accepts a byte when
  // a pop frees a slot in that cycle.
  always_comb begin
    pop  = (state_q == IDLE) && !empty_q && !tx_busy;
    push = in_valid && (!full_q || pop);
    drop = in_valid && full_q && !pop;
  end

  // Next-state for pointers, occupancy flags, overflow and the drain FSM.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_start_d = 1'b0;
    state_d     = state_q;
    wcnt_d      = wcnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      out_data_d = mem[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == (AW+1)'(DEPTH));

`ifdef UART_FIFO_OVF_STICKY_EN
    ovf_d = ovf_q | drop;
`else
    ovf_d = drop;
`endif

    case (state_q)
      IDLE: begin
        if (pop) begin
          out_start_d = 1'b1;
          wcnt_d      = '0;
          state_d     = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // Give up on a sender that never acknowledges, so the FIFO keeps draining.
        if (tx_busy)                              state_d = WAIT_DONE;
        else if (wcnt_q == WW'(BUSY_WAIT - 1))    state_d = IDLE;
        else                                      wcnt_d  = wcnt_q + WW'(1);
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_data_q  <= 8'h00;
      out_start_q <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_start_q <= out_start_d;
      wcnt_q      <= wcnt_d;
    end
  end

  // Storage array; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  assign out_data  = out_data_q;
  assign out_start = out_start_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Bench for uart_byte_fifo: scoreboard of accepted bytes, compared against
// out_data on every out_start. Honors UART_FIFO_OVF_STICKY_EN like the DUT.
module tb_uart_byte_fifo;

  localparam int AW = 4;

  logic          clk;
  logic          rstn;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          tx_busy;
  logic [7:0]    out_data;
  logic          out_start;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;

  logic          busy_force;
  logic          emu_en;
  logic          emu_busy;

  int            n_chk;
  int            n_err;
  int            n_starts;
  logic [7:0]    sb_q[$];

  assign tx_busy = emu_en ? emu_busy : busy_force;

  uart_byte_fifo #(.AW(AW), .BUSY_WAIT(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .tx_busy   (tx_busy),
    .out_data  (out_data),
    .out_start (out_start),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    in_data  = b;
    in_valid = 1'b1;
    if (accept) sb_q.push_back(b);
    tick();
    in_valid = 1'b0;
  endtask

  // Output monitor: every out_start must deliver the next scoreboard byte.
  initial begin
    logic prev_start;
    logic [7:0] exp_b;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (out_start === 1'b1) begin
        n_starts++;
        chk("no_b2b_start", {31'b0, prev_start}, 0);
        chk("sb_has_byte", (sb_q.size() > 0) ? 1 : 0, 1);
        if (sb_q.size() > 0) begin
          exp_b = sb_q.pop_front();
          chk("out_data", {24'b0, out_data}, {24'b0, exp_b});
        end
      end
      prev_start = out_start;
    end
  end

  // Sender model: busy one cycle after start, held for 10 cycles.
  initial begin
    emu_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (emu_en && out_start === 1'b1) begin
        @(posedge clk);
        #1 emu_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 emu_busy = 1'b0;
      end
    end
  end

  initial begin
    int w, t1, t2, s0;
    n_chk = 0; n_err = 0; n_starts = 0;
    rstn = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    busy_force = 1'b0; emu_en = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_start", 32'(out_start), 0);
    rstn = 1'b1;
    tick();

    // Single byte latency: out_start two cycles after the in_valid cycle
    push_byte(8'hA5, 1);
    chk("lat_no_start_c1", 32'(out_start), 0);
    chk("lat_count_c1", 32'(count), 1);
    tick();
    chk("lat_start_c2", 32'(out_start), 1);
    chk("lat_data_c2", 32'(out_data), 32'h A5);
    chk("lat_count_0", 32'(count), 0);
    chk("lat_empty", 32'(empty), 1);
    repeat (6) tick();

    // Fill to full while the sender is busy
    busy_force = 1'b1;
    s0 = n_starts;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_empty", 32'(empty), 0);
    chk("fill_no_start", 32'(n_starts - s0), 0);

    // Drop when full with no pop
    push_byte(8'hFF, 0);
    chk("drop_count", 32'(count), 16);
    chk("drop_ovf_c1", 32'(overflow), 1);
    tick();
`ifdef UART_FIFO_OVF_STICKY_EN
    chk("drop_ovf_c2", 32'(overflow), 1);
`else
    chk("drop_ovf_c2", 32'(overflow), 0);
`endif
    chk("drop_count2", 32'(count), 16);

    // Push into a full FIFO in the same cycle as a pop, then drain in order
    in_data = 8'h10; in_valid = 1'b1; sb_q.push_back(8'h10);
    emu_en = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("simul_count", 32'(count), 16);
    chk("simul_full", 32'(full), 1);
    chk("simul_start", 32'(out_start), 1);
    w = 0;
    while (sb_q.size() != 0 && w < 2000) begin tick(); w++; end
    chk("drain_done", sb_q.size(), 0);
    tick();
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);
    repeat (20) tick();
    emu_en = 1'b0;

    // Sender never acknowledges: FSM times out and issues the next start
    busy_force = 1'b1;
    push_byte(8'h33, 1);
    push_byte(8'h44, 1);
    busy_force = 1'b0;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_start === 1'b1) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
    end
    chk("starve_first", t1, 0);
    chk("starve_gap", t2 - t1, 4);

    // Reset during WAIT_DONE with five bytes still stored
    busy_force = 1'b1;
    for (int i = 0; i < 6; i++) push_byte(8'h51 + 8'(i), 1);
    busy_force = 1'b0;
    tick();
    busy_force = 1'b1;
    tick();
    tick();
    chk("pre_rst_count", 32'(count), 5);
    #2 rstn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_out_start", 32'(out_start), 0);
    sb_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    busy_force = 1'b0;
    s0 = n_starts;
    repeat (10) tick();
    chk("post_rst_no_start", 32'(n_starts - s0), 0);
    chk("post_rst_empty", 32'(empty), 1);
    push_byte(8'h77, 1);
    w = 0;
    while (sb_q.size() != 0 && w < 50) begin tick(); w++; end
    chk("post_rst_push", sb_q.size(), 0);
    chk("post_rst_starts", 32'(n_starts - s0), 1);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
